// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the datapath/control unit, the data-memory controller
// and the SRAM. The controller takes the slave view; whoever drives the
// instruction side and models the SRAM takes the master view.
interface dmem_ctrl_if;
    // Datapath / control-unit side
    logic        memRead;
    logic        memWrite;
    logic [2:0]  f3;
    logic [15:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        err;
    // SRAM side
    logic        memReq;
    logic        memWe;
    logic [13:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;

    modport master (
        output memRead, memWrite, f3, address, writeData, memRdata, memAck,
        input  readData, stall, err, memReq, memWe, memAddr, memBe, memWdata
    );

    modport slave (
        input  memRead, memWrite, f3, address, writeData, memRdata, memAck,
        output readData, stall, err, memReq, memWe, memAddr, memBe, memWdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns load/store requests from the pipeline into a
// single SRAM handshake, generates byte enables and store-data replication,
// aligns and extends load data, and flags misaligned, illegal or timed-out
// accesses with a one-cycle err pulse. err is registered, so it appears in
// the cycle after the faulty request (or in the DONE cycle for a timeout),
// aligned with the cleared readData.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // The wait counter is 5 bits wide, so TIMEOUT is taken modulo 32.
    localparam logic [4:0] TIMEOUT_C = 5'(TIMEOUT);

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [4:0]  wait_cnt_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [13:0] mem_addr_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] read_data_r;
    logic        err_r;
    logic [2:0]  f3_r;
    logic [1:0]  offset_r;
    logic        is_load_r;

    logic        issue_s;
    logic        access_ok_s;
    logic        timeout_s;
    logic        stall_s;

    // f3 codes accepted for the access direction (write wins when both set).
    function automatic logic access_legal(input logic is_write, input logic [2:0] code);
        logic ok;
        case (code)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~is_write;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural alignment for halfword and word sizes.
    function automatic logic access_aligned(input logic [2:0] code, input logic [1:0] off);
        logic ok;
        case (code[1:0])
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by the access; identical for loads and stores.
    function automatic logic [3:0] byte_mask(input logic [2:0] code, input logic [1:0] off);
        logic [3:0] be;
        case (code[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so the byte enables pick the right copy.
    function automatic logic [31:0] store_data(input logic [2:0] code, input logic [31:0] wd);
        logic [31:0] d;
        case (code[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            2'b10:   d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Shift the addressed lane down and extend per the load code.
    function automatic logic [31:0] load_extract(input logic [2:0] code, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] d;
        sh = rdata >> {off, 3'b000};
        case (code)
            3'b000:  d = {{24{sh[7]}}, sh[7:0]};
            3'b001:  d = {{16{sh[15]}}, sh[15:0]};
            3'b010:  d = sh;
            3'b100:  d = {24'h00_0000, sh[7:0]};
            3'b101:  d = {16'h0000, sh[15:0]};
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Request decode, stall and timeout detection.
    always_comb begin
        issue_s     = (state_r == IDLE) && (bus.memRead || bus.memWrite);
        access_ok_s = access_legal(bus.memWrite, bus.f3) &&
                      access_aligned(bus.f3, bus.address[1:0]);
        timeout_s   = (state_r == BUSY) && !bus.memAck &&
                      ((wait_cnt_r + 5'd1) == TIMEOUT_C);
        case (state_r)
            IDLE:    stall_s = issue_s && access_ok_s;
            BUSY:    stall_s = 1'b1;
            default: stall_s = 1'b0;
        endcase
    end

    // Next-state selection for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s && access_ok_s) state_next_s = BUSY;
                else                        state_next_s = IDLE;
            end
            BUSY: begin
                if (bus.memAck)     state_next_s = DONE;
                else if (timeout_s) state_next_s = DONE;
                else                state_next_s = BUSY;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // SRAM request registers, wait counter, load result and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r  <= 5'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 14'd0;
            mem_be_r    <= 4'd0;
            mem_wdata_r <= 32'd0;
            read_data_r <= 32'd0;
            err_r       <= 1'b0;
            f3_r        <= 3'd0;
            offset_r    <= 2'd0;
            is_load_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    err_r <= 1'b0;
                    if (issue_s && access_ok_s) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= bus.memWrite;
                        mem_addr_r  <= bus.address[15:2];
                        mem_be_r    <= byte_mask(bus.f3, bus.address[1:0]);
                        mem_wdata_r <= bus.memWrite ? store_data(bus.f3, bus.writeData) : 32'd0;
                        f3_r        <= bus.f3;
                        offset_r    <= bus.address[1:0];
                        is_load_r   <= ~bus.memWrite;
                        wait_cnt_r  <= 5'd0;
                    end else if (issue_s) begin
                        err_r <= 1'b1;
                        if (!bus.memWrite) read_data_r <= 32'd0;
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                BUSY: begin
                    err_r <= 1'b0;
                    if (bus.memAck) begin
                        mem_req_r <= 1'b0;
                        if (is_load_r) read_data_r <= load_extract(f3_r, offset_r, bus.memRdata);
                    end else if (timeout_s) begin
                        mem_req_r   <= 1'b0;
                        err_r       <= 1'b1;
                        read_data_r <= 32'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 5'd1;
                    end
                end
                DONE: begin
                    err_r <= 1'b0;
                end
                default: begin
                    err_r     <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall    = stall_s;
    assign bus.err      = err_r;
    assign bus.readData = read_data_r;
    assign bus.memReq   = mem_req_r;
    assign bus.memWe    = mem_we_r;
    assign bus.memAddr  = mem_addr_r;
    assign bus.memBe    = mem_be_r;
    assign bus.memWdata = mem_wdata_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios followed by random
// accesses, all compared against an arithmetic model of the access rules.
module tb_dmem_ctrl;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 99;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] prev_rd = 32'd0;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input bit wr, input int code);
        if (wr) return (code == 0 || code == 1 || code == 2);
        return (code == 0 || code == 1 || code == 2 || code == 4 || code == 5);
    endfunction

    function automatic int m_size(input int code);
        return 1 << (code % 4);
    endfunction

    function automatic bit m_aligned(input int code, input int addr);
        return (addr % m_size(code)) == 0;
    endfunction

    function automatic logic [31:0] m_be(input int code, input int addr);
        return 32'(((1 << m_size(code)) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input int code, input longint wd);
        case (m_size(code))
            1:       return 32'((wd % 256) * 64'h0101_0101);
            2:       return 32'((wd % 65536) * 64'h0001_0001);
            default: return 32'(wd);
        endcase
    endfunction

    function automatic logic [31:0] m_load(input int code, input int addr, input longint rdata);
        longint bits = 8 * m_size(code);
        longint v    = (rdata >> (8 * (addr % 4))) % (64'd1 << bits);
        if (code < 4 && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return 32'(v);
    endfunction

    // One complete access: issue, BUSY wait (ack on BUSY cycle ack_wait+1),
    // DONE, then two idle cycles with a stray memAck that must be ignored.
    // Entered and left just after a rising edge with the controller idle.
    task automatic run_access(input string name, input bit rd, input bit wr, input int code,
                              input int addr, input logic [31:0] wd, input logic [31:0] rdata,
                              input int ack_wait);
        bit ok;
        bit acked;
        bit tout;
        int busy;
        int stall_cnt;
        ok        = m_legal(wr, code) && m_aligned(code, addr);
        acked     = 1'b0;
        tout      = 1'b0;
        busy      = 0;
        stall_cnt = 0;
        bus.memRead   = rd;
        bus.memWrite  = wr;
        bus.f3        = 3'(code);
        bus.address   = 16'(addr);
        bus.writeData = wd;
        bus.memAck    = 1'b0;
        @(negedge clk);
        check({name, " issue stall"}, 32'(bus.stall), 32'(ok));
        check({name, " issue memReq"}, 32'(bus.memReq), 32'd0);
        stall_cnt += int'(bus.stall);
        @(posedge clk); #1;
        if (!ok) begin
            bus.memRead  = 1'b0;
            bus.memWrite = 1'b0;
            if (!wr) prev_rd = 32'd0;
            @(negedge clk);
            check({name, " err pulse"}, 32'(bus.err), 32'd1);
            check({name, " err memReq"}, 32'(bus.memReq), 32'd0);
            check({name, " err stall"}, 32'(bus.stall), 32'd0);
            check({name, " err readData"}, bus.readData, prev_rd);
            @(posedge clk); #1;
            @(negedge clk);
            check({name, " err ends"}, 32'(bus.err), 32'd0);
            check({name, " err no req"}, 32'(bus.memReq), 32'd0);
            @(posedge clk); #1;
        end else begin
            while (!acked && !tout) begin
                busy++;
                bus.memAck   = (busy == ack_wait + 1);
                bus.memRdata = bus.memAck ? rdata : $urandom();
                @(negedge clk);
                stall_cnt += int'(bus.stall);
                check({name, " busy memReq"}, 32'(bus.memReq), 32'd1);
                check({name, " busy memWe"}, 32'(bus.memWe), 32'(wr));
                check({name, " busy memAddr"}, 32'(bus.memAddr), 32'(addr / 4));
                check({name, " busy memBe"}, 32'(bus.memBe), m_be(code, addr));
                if (wr) check({name, " busy memWdata"}, bus.memWdata, m_wdata(code, longint'(wd)));
                check({name, " busy err"}, 32'(bus.err), 32'd0);
                @(posedge clk); #1;
                if (bus.memAck) acked = 1'b1;
                else if (busy == TIMEOUT) tout = 1'b1;
            end
            if (tout) prev_rd = 32'd0;
            else if (!wr) prev_rd = m_load(code, addr, longint'(rdata));
            bus.memAck   = 1'b1;
            bus.memRdata = $urandom();
            @(negedge clk);
            check({name, " done memReq"}, 32'(bus.memReq), 32'd0);
            check({name, " done stall"}, 32'(bus.stall), 32'd0);
            check({name, " done err"}, 32'(bus.err), 32'(tout));
            check({name, " done readData"}, bus.readData, prev_rd);
            check({name, " stall cycles"}, 32'(stall_cnt), 32'(tout ? TIMEOUT + 1 : ack_wait + 2));
            @(posedge clk); #1;
            bus.memRead  = 1'b0;
            bus.memWrite = 1'b0;
            @(negedge clk);
            check({name, " idle stall"}, 32'(bus.stall), 32'd0);
            check({name, " idle memReq"}, 32'(bus.memReq), 32'd0);
            check({name, " idle err"}, 32'(bus.err), 32'd0);
            check({name, " idle readData"}, bus.readData, prev_rd);
            @(posedge clk); #1;
            bus.memAck = 1'b0;
            @(negedge clk);
            check({name, " stray ack memReq"}, 32'(bus.memReq), 32'd0);
            check({name, " stray ack readData"}, bus.readData, prev_rd);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int rw;
        int code;
        int addr;
        int aw;
        rst           = 1'b1;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        bus.f3        = 3'd0;
        bus.address   = 16'd0;
        bus.writeData = 32'd0;
        bus.memRdata  = 32'd0;
        bus.memAck    = 1'b0;
        #2;
        check("reset memReq", 32'(bus.memReq), 32'd0);
        check("reset memBe", 32'(bus.memBe), 32'd0);
        check("reset memAddr", 32'(bus.memAddr), 32'd0);
        check("reset readData", bus.readData, 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        check("reset stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // lw, ack on the second BUSY cycle
        run_access("lw 0x0010", 1'b1, 1'b0, 2, 16'h0010, 32'd0, 32'hDEAD_BEEF, 1);
        check("lw const readData", bus.readData, 32'hDEAD_BEEF);
        // lb / lbu on the top lane
        run_access("lb 0x0013", 1'b1, 1'b0, 0, 16'h0013, 32'd0, 32'h8000_0000, 0);
        check("lb const readData", bus.readData, 32'hFFFF_FF80);
        run_access("lbu 0x0013", 1'b1, 1'b0, 4, 16'h0013, 32'd0, 32'h8000_0000, 0);
        check("lbu const readData", bus.readData, 32'h0000_0080);
        // stores: readData must hold the lbu result
        run_access("sh 0x0022", 1'b0, 1'b1, 1, 16'h0022, 32'h1234_ABCD, 32'd0, 2);
        run_access("sb 0x0021", 1'b0, 1'b1, 0, 16'h0021, 32'h1234_ABCD, 32'd0, 0);
        check("store keeps readData", bus.readData, 32'h0000_0080);
        // both set -> write; lhu / lh
        run_access("rd+wr sw", 1'b1, 1'b1, 2, 16'h0104, 32'hCAFE_F00D, 32'h1111_1111, 0);
        run_access("lhu 0x0102", 1'b1, 1'b0, 5, 16'h0102, 32'd0, 32'h9ABC_1234, 3);
        run_access("lh 0x0102", 1'b1, 1'b0, 1, 16'h0102, 32'd0, 32'h9ABC_1234, 0);
        // misaligned and illegal
        run_access("lw 0x0006", 1'b1, 1'b0, 2, 16'h0006, 32'd0, 32'd0, 0);
        run_access("sbu illegal", 1'b0, 1'b1, 4, 16'h0000, 32'h5555_5555, 32'd0, 0);
        run_access("f3=011 load", 1'b1, 1'b0, 3, 16'h0008, 32'd0, 32'd0, 0);
        // ack on the very last allowed BUSY cycle, then a full timeout
        run_access("lw ack last", 1'b1, 1'b0, 2, 16'h0200, 32'd0, 32'h7777_0001, TIMEOUT - 1);
        run_access("lw timeout", 1'b1, 1'b0, 2, 16'h0300, 32'd0, 32'h0, NEVER);

        // reset on the second BUSY cycle
        run_access("pre-reset lw", 1'b1, 1'b0, 2, 16'h0040, 32'd0, 32'h0BAD_CAFE, 0);
        bus.memRead  = 1'b1;
        bus.f3       = 3'd2;
        bus.address  = 16'h0044;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst pre memReq", 32'(bus.memReq), 32'd1);
        #2;
        rst         = 1'b1;
        bus.memRead = 1'b0;
        #1;
        check("rst async memReq", 32'(bus.memReq), 32'd0);
        check("rst async stall", 32'(bus.stall), 32'd0);
        check("rst async memBe", 32'(bus.memBe), 32'd0);
        check("rst async readData", bus.readData, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        prev_rd      = 32'd0;
        bus.memAck   = 1'b1;
        bus.memRdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        @(negedge clk);
        check("late ack memReq", 32'(bus.memReq), 32'd0);
        check("late ack stall", 32'(bus.stall), 32'd0);
        check("late ack readData", bus.readData, 32'd0);
        check("late ack err", 32'(bus.err), 32'd0);
        bus.memAck = 1'b0;
        @(posedge clk); #1;

        // random accesses
        for (int i = 0; i < 40; i++) begin
            rw   = int'($urandom_range(1, 3));
            code = int'($urandom_range(0, 7));
            addr = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 0) addr = addr & 16'hFFFC;
            aw   = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
            run_access($sformatf("rand%0d", i), rw[0], rw[1], code, addr,
                       $urandom(), $urandom(), aw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles spent in BUSY waiting for memAck.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port memRead, input, 1 bit: the current instruction is a load (from control unit).
REQ-005 The block SHALL have port memWrite, input, 1 bit: the current instruction is a store (from control unit).
REQ-006 The block SHALL have port f3, input, 3 bits: instr[14:12], the access size/sign code.
REQ-007 The block SHALL have port address, input, 16 bits: byte address (ALU result from datapath).
REQ-008 The block SHALL have port writeData, input, 32 bits: store data (rs2 from datapath).
REQ-009 The block SHALL have port readData, output, 32 bits: extended load result to datapath.
REQ-010 The block SHALL have port stall, output, 1 bit: freezes PC/register-file write in the datapath.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse flagging a misaligned, illegal or timed-out access.
REQ-012 The block SHALL have ports memReq (output, 1 bit), memWe (output, 1 bit), memAddr (output, 14 bits, word address), memBe (output, 4 bits, byte enables), memWdata (output, 32 bits), memRdata (input, 32 bits) and memAck (input, 1 bit): the SRAM-side handshake.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 In IDLE, an access SHALL be issued when memRead|memWrite; if both are set, the access SHALL be a write.
REQ-015 Legal f3 values SHALL be: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw; any other f3 SHALL be illegal.
REQ-016 Alignment SHALL require address[0]=0 for halfword and address[1:0]=00 for word accesses.
REQ-017 A legal, aligned access in IDLE SHALL register memAddr=address[15:2], memWe, memBe and memWdata, assert memReq, and move to BUSY on the next edge.
REQ-018 An illegal or misaligned access in IDLE SHALL pulse err for that cycle, keep memReq=0, keep stall=0, load readData=0 (loads only), and remain in IDLE.
REQ-019 Byte enables SHALL be: sb 0001<<address[1:0], data {4{wd[7:0]}}; sh 0011 (address[1]=0) or 1100, data {2{wd[15:0]}}; sw/lw 1111, data wd; for loads memBe SHALL equal the access-size mask.
REQ-020 stall SHALL be combinational: 1 in IDLE with a legal issuing access, 1 in BUSY, 0 otherwise.
REQ-021 In BUSY, memReq, memWe, memAddr, memBe and memWdata SHALL stay stable until memAck.
REQ-022 On memAck in BUSY, memReq SHALL drop at the next edge and the state SHALL move to DONE; for loads, readData SHALL be registered from memRdata shifted by the byte offset and sign- or zero-extended per f3.
REQ-023 A 5-bit wait counter SHALL clear on entering BUSY and increment each BUSY cycle without memAck.
REQ-024 When the counter reaches TIMEOUT without memAck, the FSM SHALL drop memReq, pulse err, set readData=0 and move to DONE.
REQ-025 DONE SHALL last exactly one cycle with stall=0 (instruction retires), SHALL ignore memRead/memWrite, and SHALL return to IDLE.
REQ-026 memAck in IDLE or DONE SHALL be ignored.
REQ-027 readData SHALL hold its value until the next completed load or error.
REQ-028 Access latency SHALL be 1 issue cycle, plus the wait cycles until ack, plus 1 DONE cycle; with ack on the first BUSY cycle, stall SHALL be high for 2 cycles.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, memReq=0, memWe=0, memBe=0, memAddr=0, memWdata=0, readData=0, err=0 and counter=0, including mid-BUSY; no access SHALL resume after reset.

Verification
REQ-030 Test lw at 0x0010 with ack after 2 cycles and memRdata=0xDEADBEEF -> memAddr=0x0004, memBe=1111, stall high 3 cycles, readData=0xDEADBEEF in DONE.
REQ-031 Test lb at 0x0013 with memRdata=0x80000000 -> memBe=1000, readData=0xFFFFFF80; test lbu at the same address -> readData=0x00000080.
REQ-032 Test sh at 0x0022 with writeData=0x1234ABCD -> memWe=1, memBe=1100, memWdata=0xABCDABCD; test sb at 0x0021 -> memBe=0010.
REQ-033 Test lw at 0x0006 -> err pulse for 1 cycle, memReq never asserts, stall=0, readData=0.
REQ-034 Test a load with memAck held low -> after 15 BUSY cycles memReq=0, err pulses, readData=0, FSM passes through DONE and returns to IDLE.
REQ-035 Test rst asserted on the 2nd BUSY cycle -> memReq=0 asynchronously, FSM in IDLE, and a late memAck is ignored.
